// File: rtl/pwm_edge_pkg.sv
// Shared definitions for the PWM / edge-counter block: reset defaults,
// per-channel config record and channel-index width helper.
package pwm_edge_pkg;

  localparam int unsigned DEF_PERIOD = 10;
  localparam int unsigned DEF_HIGH   = 3;

  // Config fields are stored at this fixed width; PER_W must not exceed it.
  localparam int unsigned CFG_W = 32;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
  } chan_cfg_t;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_edge_channel.sv
// One PWM channel: phase counter, registered output, pending config slot
// and rise/fall edge counters.
module pwm_edge_channel
  import pwm_edge_pkg::*;
#(
  parameter int unsigned PER_W      = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = pwm_edge_pkg::DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = pwm_edge_pkg::DEF_HIGH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear_counts,
  input  logic             cfg_we,
  input  chan_cfg_t        cfg_in,
  output logic             pending,
  output logic             pwm_out,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count
);

  logic [PER_W-1:0] phase_q, phase_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] high_q, high_d;
  logic             out_q, out_d;
  logic             pending_q, pending_d;
  chan_cfg_t        pend_q, pend_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;

  logic idle;
  logic last;
  logic apply;

  always_comb begin
    phase_d   = phase_q;
    per_d     = per_q;
    high_d    = high_q;
    out_d     = out_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    rise_d    = rise_q;
    fall_d    = fall_q;

    idle = (per_q < PER_W'(2));
    // >= rather than == so a phase left beyond a newly shortened period still wraps
    last = !idle && (phase_q >= PER_W'(per_q - PER_W'(1)));

    if (enable) begin
      if (idle) begin
        phase_d = '0;
        out_d   = 1'b0;
      end else begin
        phase_d = last ? '0 : PER_W'(phase_q + PER_W'(1));
        out_d   = (phase_q < high_q);
      end
    end

    // Disabled or idle channels have no period boundary to wait for.
    apply = pending_q && (!enable || idle || last);
    if (apply) begin
      per_d     = pend_q.period[PER_W-1:0];
      high_d    = pend_q.high[PER_W-1:0];
      pending_d = 1'b0;
    end else if (cfg_we && !pending_q) begin
      pend_d    = cfg_in;
      pending_d = 1'b1;
    end

    if (clear_counts) begin
      rise_d = '0;
      fall_d = '0;
    end else begin
      if (!out_q && out_d) rise_d = CNT_W'(rise_q + CNT_W'(1));
      if (out_q && !out_d) fall_d = CNT_W'(fall_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q   <= '0;
      per_q     <= PER_W'(DEF_PERIOD);
      high_q    <= PER_W'(DEF_HIGH);
      out_q     <= 1'b0;
      pending_q <= 1'b0;
      pend_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      per_q     <= per_d;
      high_q    <= high_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign pending    = pending_q;
  assign pwm_out    = out_q;
  assign rise_count = rise_q;
  assign fall_count = fall_q;

endmodule

// File: rtl/pwm_edge_counter.sv
// Multi-channel PWM generator with per-channel edge counters and a global
// elapsed-cycle counter; channels are reprogrammed through a valid/ready port.
module pwm_edge_counter
  import pwm_edge_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned PER_W      = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = pwm_edge_pkg::DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = pwm_edge_pkg::DEF_HIGH,
  localparam int unsigned CH_W      = ch_idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear_counts,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [PER_W-1:0]          cfg_period,
  input  logic [PER_W-1:0]          cfg_high,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*CNT_W-1:0] rise_count,
  output logic [CHANNELS*CNT_W-1:0] fall_count,
  output logic [CNT_W-1:0]          elapsed
);

  // Handshake: a config word transfers on a clk edge where cfg_valid and
  // cfg_ready are both high; cfg_ready only depends on the addressed channel.
  localparam int unsigned PAD_W = 2 ** CH_W;

  logic [CHANNELS-1:0] pending;
  logic [PAD_W-1:0]    pending_pad;
  logic [CHANNELS-1:0] cfg_we;
  chan_cfg_t           cfg_in;
  logic [CNT_W-1:0]    elapsed_q, elapsed_d;

  // Out-of-range channel indices read as not pending, so they are accepted and dropped.
  assign pending_pad = PAD_W'(pending);
  assign cfg_ready   = !pending_pad[cfg_ch];

  always_comb begin
    cfg_in        = '0;
    cfg_in.period = CFG_W'(cfg_period);
    cfg_in.high   = CFG_W'(cfg_high);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    pwm_edge_channel #(
      .PER_W      (PER_W),
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .clear_counts (clear_counts),
      .cfg_we       (cfg_we[i]),
      .cfg_in       (cfg_in),
      .pending      (pending[i]),
      .pwm_out      (pwm_out[i]),
      .rise_count   (rise_count[i*CNT_W +: CNT_W]),
      .fall_count   (fall_count[i*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    elapsed_d = elapsed_q;
    if (clear_counts)  elapsed_d = '0;
    else if (enable)   elapsed_d = CNT_W'(elapsed_q + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) elapsed_q <= '0;
    else          elapsed_q <= elapsed_d;
  end

  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_pwm_edge_counter.sv
// Directed bench for pwm_edge_counter: a default-width instance plus a
// 4-bit-counter instance driven by the same stimulus.
module tb_pwm_edge_counter;

  localparam int CH = 2;
  localparam int PW = 16;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          clear_counts;
  logic          cfg_valid;
  logic          cfg_ch;
  logic [PW-1:0] cfg_period;
  logic [PW-1:0] cfg_high;

  logic          cfg_ready,  cfg_ready4;
  logic [CH-1:0] pwm_out,    pwm_out4;
  logic [63:0]   rise_count, fall_count;
  logic [7:0]    rise4,      fall4;
  logic [31:0]   elapsed;
  logic [3:0]    elapsed4;

  int n_checks;
  int n_errors;

  pwm_edge_counter #(.CHANNELS(CH), .PER_W(PW), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_counts(clear_counts),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .pwm_out(pwm_out),
    .rise_count(rise_count), .fall_count(fall_count), .elapsed(elapsed)
  );

  pwm_edge_counter #(.CHANNELS(CH), .PER_W(PW), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_counts(clear_counts),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .pwm_out(pwm_out4),
    .rise_count(rise4), .fall_count(fall4), .elapsed(elapsed4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic ch, input int per, input int high);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_period = PW'(per);
    cfg_high   = PW'(high);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset_n      = 1'b0;
    enable       = 1'b0;
    clear_counts = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = 1'b0;
    cfg_period   = '0;
    cfg_high     = '0;
    step(2);

    // Reset state
    check("rst_pwm",     pwm_out,    0);
    check("rst_rise",    rise_count, 0);
    check("rst_fall",    fall_count, 0);
    check("rst_elapsed", elapsed,    0);
    check("rst_ready0",  cfg_ready,  1);
    cfg_ch = 1'b1;
    check("rst_ready1",  cfg_ready,  1);
    cfg_ch = 1'b0;

    // Defaults P=10 H=3 from the first enabled edge
    reset_n = 1'b1;
    enable  = 1'b1;
    step(1);
    check("e1_pwm",   pwm_out,          2'b11);
    check("e1_rise0", rise_count[31:0], 1);
    step(2);
    check("e3_pwm",   pwm_out,          2'b11);
    step(1);
    check("e4_pwm",   pwm_out,          2'b00);
    check("e4_fall0", fall_count[31:0], 1);
    step(7);
    check("e11_rise", rise_count,       {32'd2, 32'd2});
    step(89);
    check("e100_rise",    rise_count, {32'd10, 32'd10});
    check("e100_fall",    fall_count, {32'd10, 32'd10});
    check("e100_elapsed", elapsed,    100);
    check("e100_pwm",     pwm_out,    2'b00);
    check("e100_el4",     elapsed4,   4);
    step(60);
    check("e160_rise",  rise_count, {32'd16, 32'd16});
    check("e160_rise4", rise4,      0);
    check("e160_fall4", fall4,      0);
    check("e160_el4",   elapsed4,   0);

    // ch1 P=4 H=2 written at phase 5; applies when phase 9 wraps
    step(5);
    send_cfg(1'b1, 4, 2);
    check("cfg1_ready_pre", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    check("cfg1_ready_lo", cfg_ready, 0);
    step(3);
    check("e169_ready", cfg_ready, 0);
    step(1);
    check("e170_ready", cfg_ready, 1);
    check("e170_pwm",   pwm_out,   2'b00);
    step(1);
    check("e171_pwm",   pwm_out,   2'b11);
    step(2);
    check("e173_pwm",   pwm_out,   2'b01);
    step(1);
    check("e174_pwm",   pwm_out,   2'b00);
    step(1);
    check("e175_pwm",   pwm_out,   2'b10);
    check("e175_rise",  rise_count, {32'd19, 32'd18});

    // clear_counts on the edge where ch1 rises
    step(3);
    clear_counts = 1'b1;
    step(1);
    clear_counts = 1'b0;
    check("clr_pwm",     pwm_out,    2'b10);
    check("clr_rise",    rise_count, 0);
    check("clr_fall",    fall_count, 0);
    check("clr_elapsed", elapsed,    0);
    check("clr_el4",     elapsed4,   0);
    step(2);
    check("e181_pwm",  pwm_out,    2'b01);
    check("e181_rise", rise_count, {32'd0, 32'd1});
    check("e181_fall", fall_count, {32'd1, 32'd0});
    check("e181_el",   elapsed,    2);

    // enable low for 7 cycles mid-period
    enable = 1'b0;
    step(7);
    check("frz_pwm",  pwm_out,    2'b01);
    check("frz_rise", rise_count, {32'd0, 32'd1});
    check("frz_fall", fall_count, {32'd1, 32'd0});
    check("frz_el",   elapsed,    2);
    enable = 1'b1;
    step(2);
    check("res_pwm",  pwm_out,    2'b11);
    check("res_rise", rise_count, {32'd1, 32'd1});
    check("res_el",   elapsed,    4);
    step(1);
    check("res2_pwm",  pwm_out,    2'b10);
    check("res2_fall", fall_count, {32'd1, 32'd1});
    check("res2_el4",  elapsed4,   5);

    // ch0 H=0 written while disabled: applies on the next edge
    enable = 1'b0;
    send_cfg(1'b0, 10, 0);
    check("h0_ready_pre", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    check("h0_ready_lo", cfg_ready, 0);
    step(1);
    check("h0_ready_hi", cfg_ready, 1);
    check("h0_pwm_frz",  pwm_out,   2'b10);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("h0_low", pwm_out[0], 0);
    end
    check("h0_rise0", rise_count[31:0], 1);

    // ch0 H=P=6: one rise after apply, then constantly high
    send_cfg(1'b0, 6, 6);
    step(1);
    cfg_valid = 1'b0;
    step(4);
    check("hp_ready_lo", cfg_ready,  0);
    check("hp_pwm_pre",  pwm_out[0], 0);
    step(1);
    check("hp_ready_hi", cfg_ready,  1);
    check("hp_pwm_ap",   pwm_out[0], 0);
    step(1);
    check("hp_pwm_on",   pwm_out[0],       1);
    check("hp_rise0",    rise_count[31:0], 2);
    step(12);
    check("hp_pwm_hold", pwm_out[0],       1);
    check("hp_rise_hld", rise_count[31:0], 2);
    check("hp_fall_hld", fall_count[31:0], 1);

    // one-cycle reset with pending config and nonzero counts
    send_cfg(1'b1, 8, 4);
    check("rp_ready_pre", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    check("rp_ready_lo", cfg_ready, 0);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("rp_pwm",   pwm_out,    0);
    check("rp_rise",  rise_count, 0);
    check("rp_fall",  fall_count, 0);
    check("rp_el",    elapsed,    0);
    check("rp_ready", cfg_ready,  1);
    check("rp_rise4", rise4,      0);
    step(1);
    check("rp_e1_pwm",  pwm_out,    2'b11);
    check("rp_e1_rise", rise_count, {32'd1, 32'd1});
    step(3);
    check("rp_e4_pwm",  pwm_out,    2'b00);
    check("rp_e4_fall", fall_count, {32'd1, 32'd1});
    check("rp_e4_el",   elapsed,    4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_edge_counter.md
# pwm_edge_counter

Synthesisable, parametrised successor to the fixed 30 %-duty clock generator and edge counter. Generates `CHANNELS` independent divided-clock/PWM outputs from the system clock, each with a runtime-programmable period and high time, and keeps per-channel rising- and falling-edge counts plus a global elapsed-cycle count. Sits next to the clock source as a timing and stimulus utility; software or a test sequencer reprograms channels through a valid/ready config port.

## Interface
- `CHANNELS`, 2: number of independent output channels (1..8).
- `PER_W`, 16: width of the period and high-time fields.
- `CNT_W`, 32: width of each edge counter and of the elapsed counter.
- `DEF_PERIOD`, 10: period in clk cycles after reset.
- `DEF_HIGH`, 3: high time after reset (30 % duty).
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: global run; when low, all phases, outputs and counters freeze.
- `clear_counts` in 1: synchronous clear of all edge counters and `elapsed`.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: `!pending[cfg_ch]`.
- `cfg_ch` in $clog2(CHANNELS) (min 1): target channel.
- `cfg_period` in PER_W: new period in cycles.
- `cfg_high` in PER_W: new high time in cycles.
- `pwm_out` out CHANNELS: registered channel outputs.
- `rise_count` out CHANNELS*CNT_W: per-channel rising-edge counts, channel 0 in the LSBs.
- `fall_count` out CHANNELS*CNT_W: per-channel falling-edge counts.
- `elapsed` out CNT_W: number of enabled clk cycles.

## Operation
- Per channel: `phase` counts 0..P-1 on enabled cycles and wraps to 0 after P-1. On each enabled edge: `out <= (phase < H)`.
- Rise count increments when `!out && next_out`. Fall count increments when `out && !next_out`.
- Degenerate settings:
  - H = 0: output is constantly low.
  - H >= P: output is constantly high after the first edge (one rise, no falls).
  - P < 2: channel idle; phase is held at 0, output is low, counts hold. A falling edge is counted if the output was high.
- Config handshake:
  - Accept when `cfg_valid && cfg_ready`.
  - The accepted value is latched into the channel's pending register and `pending` is set.
  - Pending applies at the enabled edge where `phase == P-1`; the new P/H are used from phase 0 of the next period.
  - If the channel is idle (P < 2) or `enable` is low, pending applies on the next clk edge.
  - Applying clears `pending`.
  - Config for other channels is unaffected.
- Counters wrap modulo 2^CNT_W, with no saturation.
- `clear_counts` has priority over a same-cycle increment: the result is 0, not 1. It does not touch phase, out or config.
- `enable` low: everything holds, except pending-config apply and `clear_counts`.
- Reset values:
  - phase = 0, `pwm_out` = 0, all counts = 0, `elapsed` = 0.
  - P = DEF_PERIOD, H = DEF_HIGH.
  - `pending` = 0 and `cfg_ready` = 1; in-flight pending config is discarded.
  - Reset mid-period restarts cleanly from phase 0.

## Timing
- Latency: `pwm_out` reflects the phase of the previous cycle (1 register stage). Counts update on the same edge as `pwm_out`.
- With defaults and `enable` high from the first cycle after reset release:
  - Edge 1: `pwm_out` = 1, rise = 1.
  - Edge 4: `pwm_out` = 0, fall = 1.
  - Edge 11: rise = 2.
  - `elapsed` equals the number of enabled edges.
- `cfg_ready` drops the cycle after acceptance for that channel. It rises the cycle after the apply edge.
- No combinational path from any input to any output except `cfg_ch` → `cfg_ready`.

## Structure
- Package `pwm_edge_pkg`:
  - DEF_PERIOD and DEF_HIGH defaults.
  - `chan_cfg_t` struct {period, high}.
  - Channel-index width function.
- Sub-module `pwm_edge_channel`: phase counter, output register, pending config, rise/fall counters. Generated CHANNELS times.
- Top level: config demux, `elapsed` counter, output packing.

## Test plan
- Reset, then enable with defaults for 100 edges → per channel rise = 10, fall = 10, `elapsed` = 100; high for 3 of every 10 cycles.
- Write ch1 P = 4, H = 2 mid-period (phase 5) → ch1 keeps P = 10 until phase 9 wraps, then toggles 2 high / 2 low; `cfg_ready` for ch1 is low until apply; ch0 is unchanged.
- H = 0, then H = P = 6 on ch0 → output stays low; then exactly one rise and no falls after apply.
- `clear_counts` on the same edge as a rising edge → rise = 0 that cycle, not 1; `elapsed` = 0.
- CNT_W = 4, run 16 periods → rise wraps to 0; `enable` low for 7 cycles mid-period → phase, output, counts and `elapsed` frozen, then resume at the same phase.
- Deassert `reset_n` for one cycle with pending config and nonzero counts → all outputs at reset values next edge, pending discarded, default P/H resume.
